nubus_slave: RTL and testbench

NuBus slave-side transaction engine that sits directly upstream of the card's local memory port. It samples NuBus start cycles, decodes slot/superslot address and transfer mode, and converts each accepted transaction into one `mem_valid`/`mem_ready` request. Once the request completes or times out, it returns an acknowledge cycle to the bus, carrying status and read data.

---
 rtl/nubus_pkg.sv | 43 ++++
 rtl/nubus_slave_decode.sv | 27 ++
 rtl/nubus_slave.sv | 168 ++++++++++++++++
 tb/tb_nubus_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// Shared types, status codes and transfer-mode decode for the NuBus slave engine.
package nubus_pkg;

  localparam int unsigned AD_W   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    BUSY = 2'd2,
    ACK  = 2'd3
  } state_t;

  // {tm1n, tm0n} driven during the acknowledge cycle
  localparam logic [1:0] ST_COMPLETE = 2'b11;
  localparam logic [1:0] ST_ERROR    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;

  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic              unsup;
  } tm_dec_t;

  // Map start-cycle transfer mode and low address bits to byte strobes.
  function automatic tm_dec_t tm_decode(input logic tm0n, input logic [1:0] lane);
    tm_dec_t d;
    d.strb  = '0;
    d.unsup = 1'b0;
    if (tm0n) begin
      d.strb = STRB_W'(4'b0001 << lane);
    end else begin
      case (lane)
        2'b00:   d.strb = 4'b1111;
        2'b10:   d.strb = 4'b1100;
        2'b01:   d.strb = 4'b0011;
        default: d.unsup = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// Combinational start-cycle decode: slot/superslot hit and byte strobes.
module nubus_slave_decode
  import nubus_pkg::*;
#(
  parameter int unsigned SUPERSLOT_EN = 1
) (
  input  logic [3:0] nub_idn,
  input  logic [7:0] ad_hi,
  input  logic [1:0] ad_lo,
  input  logic       tm0n,
  output logic       hit_slot_c,
  output logic       hit_exp_c,
  output tm_dec_t    dec_c
);

  logic [3:0] slot_id;

  assign slot_id = ~nub_idn;

  // Address space hits and transfer-mode strobes
  always_comb begin
    hit_slot_c = (ad_hi == {4'hF, slot_id});
    hit_exp_c  = (SUPERSLOT_EN != 0) && (ad_hi[7:4] == slot_id) && (slot_id != 4'h0);
    dec_c      = tm_decode(tm0n, ad_lo);
  end

endmodule

// File: rtl/nubus_slave.sv
// NuBus slave transaction engine: start decode, one memory request, ack cycle.
module nubus_slave
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned SUPERSLOT_EN = 1
) (
  input  logic              nub_clk,
  input  logic              nub_reset,
  input  logic [3:0]        nub_idn,
  input  logic              nub_startn,
  input  logic [AD_W-1:0]   nub_ad_i,
  input  logic              nub_tm1n_i,
  input  logic              nub_tm0n_i,
  output logic              nub_ackn_o,
  output logic              nub_tm1n_o,
  output logic              nub_tm0n_o,
  output logic              nub_ack_oe,
  output logic [AD_W-1:0]   nub_ad_o,
  output logic              nub_ad_oe,
  output logic              mem_valid,
  output logic [AD_W-1:0]   mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [AD_W-1:0]   mem_wdata,
  output logic              mem_myslot,
  output logic              mem_myexp,
  input  logic [AD_W-1:0]   mem_rdata,
  input  logic              mem_ready
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              is_write, is_write_d;
  logic              unsup, unsup_d;
  logic              ackn_d, tm1n_d, tm0n_d, ack_oe_d, ad_oe_d, valid_d;
  logic              myslot_d, myexp_d;
  logic [AD_W-1:0]   ad_o_d, addr_d, wdata_d;
  logic [STRB_W-1:0] wstrb_d;

  logic              hit_slot_c, hit_exp_c;
  tm_dec_t           dec_c;

  nubus_slave_decode #(.SUPERSLOT_EN(SUPERSLOT_EN)) u_decode (
    .nub_idn    (nub_idn),
    .ad_hi      (nub_ad_i[31:24]),
    .ad_lo      (nub_ad_i[1:0]),
    .tm0n       (nub_tm0n_i),
    .hit_slot_c (hit_slot_c),
    .hit_exp_c  (hit_exp_c),
    .dec_c      (dec_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    is_write_d = is_write;
    unsup_d    = unsup;
    ackn_d     = nub_ackn_o;
    tm1n_d     = nub_tm1n_o;
    tm0n_d     = nub_tm0n_o;
    ack_oe_d   = nub_ack_oe;
    ad_o_d     = nub_ad_o;
    ad_oe_d    = nub_ad_oe;
    valid_d    = mem_valid;
    addr_d     = mem_addr;
    wstrb_d    = mem_wstrb;
    wdata_d    = mem_wdata;
    myslot_d   = mem_myslot;
    myexp_d    = mem_myexp;
    case (state)
      IDLE: begin
        if (!nub_startn && (hit_slot_c || hit_exp_c)) begin
          state_d    = DATA;
          addr_d     = {nub_ad_i[31:2], 2'b00};
          is_write_d = !nub_tm1n_i;
          unsup_d    = dec_c.unsup;
          wstrb_d    = nub_tm1n_i ? '0 : dec_c.strb;
          myslot_d   = hit_slot_c;
          myexp_d    = hit_exp_c;
        end
      end
      DATA: begin
        if (unsup) begin
          state_d          = ACK;
          ackn_d           = 1'b0;
          ack_oe_d         = 1'b1;
          {tm1n_d, tm0n_d} = ST_ERROR;
        end else begin
          state_d = BUSY;
          valid_d = 1'b1;
          cnt_d   = '0;
          if (is_write) wdata_d = nub_ad_i;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d          = ACK;
          valid_d          = 1'b0;
          ackn_d           = 1'b0;
          ack_oe_d         = 1'b1;
          {tm1n_d, tm0n_d} = ST_COMPLETE;
          ad_o_d           = mem_rdata;
          ad_oe_d          = !is_write;
        end else if (cnt == TMO_LAST) begin
          state_d          = ACK;
          valid_d          = 1'b0;
          ackn_d           = 1'b0;
          ack_oe_d         = 1'b1;
          {tm1n_d, tm0n_d} = ST_TIMEOUT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ACK: begin
        state_d  = IDLE;
        ackn_d   = 1'b1;
        tm1n_d   = 1'b1;
        tm0n_d   = 1'b1;
        ack_oe_d = 1'b0;
        ad_oe_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_write   <= 1'b0;
      unsup      <= 1'b0;
      nub_ackn_o <= 1'b1;
      nub_tm1n_o <= 1'b1;
      nub_tm0n_o <= 1'b1;
      nub_ack_oe <= 1'b0;
      nub_ad_o   <= '0;
      nub_ad_oe  <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      mem_myslot <= 1'b0;
      mem_myexp  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      is_write   <= is_write_d;
      unsup      <= unsup_d;
      nub_ackn_o <= ackn_d;
      nub_tm1n_o <= tm1n_d;
      nub_tm0n_o <= tm0n_d;
      nub_ack_oe <= ack_oe_d;
      nub_ad_o   <= ad_o_d;
      nub_ad_oe  <= ad_oe_d;
      mem_valid  <= valid_d;
      mem_addr   <= addr_d;
      mem_wstrb  <= wstrb_d;
      mem_wdata  <= wdata_d;
      mem_myslot <= myslot_d;
      mem_myexp  <= myexp_d;
    end
  end

endmodule

// File: tb/tb_nubus_slave.sv
// Directed, table-driven bench for nubus_slave (slot 0xE, TIMEOUT 4).
module tb_nubus_slave;

  logic        nub_clk;
  logic        nub_reset;
  logic [3:0]  nub_idn;
  logic        nub_startn;
  logic [31:0] nub_ad_i;
  logic        nub_tm1n_i;
  logic        nub_tm0n_i;
  logic        nub_ackn_o;
  logic        nub_tm1n_o;
  logic        nub_tm0n_o;
  logic        nub_ack_oe;
  logic [31:0] nub_ad_o;
  logic        nub_ad_oe;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_myslot;
  logic        mem_myexp;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ready_en;

  int n_checks = 0;
  int n_fail   = 0;

  nubus_slave #(.TIMEOUT(4), .SUPERSLOT_EN(1)) dut (
    .nub_clk    (nub_clk),
    .nub_reset  (nub_reset),
    .nub_idn    (nub_idn),
    .nub_startn (nub_startn),
    .nub_ad_i   (nub_ad_i),
    .nub_tm1n_i (nub_tm1n_i),
    .nub_tm0n_i (nub_tm0n_i),
    .nub_ackn_o (nub_ackn_o),
    .nub_tm1n_o (nub_tm1n_o),
    .nub_tm0n_o (nub_tm0n_o),
    .nub_ack_oe (nub_ack_oe),
    .nub_ad_o   (nub_ad_o),
    .nub_ad_oe  (nub_ad_oe),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_myslot (mem_myslot),
    .mem_myexp  (mem_myexp),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // Memory answers while ready_en is set
  assign mem_ready = mem_valid & ready_en;

  initial nub_clk = 1'b0;
  always #5 nub_clk = ~nub_clk;

  typedef struct {
    logic [31:0] ad;
    logic        tm1n;
    logic        tm0n;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic        exp_slot;
    logic        exp_exp;
    int          exp_ack;
    logic [1:0]  exp_st;
    logic        exp_ad_oe;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start cycle 0, data in cycle 1, observe cycles 1..10 one tick after each edge
  task automatic run_vec(input int idx, input vec_t v);
    logic        seen_valid, valid_in_ack, oe_bad, extra_valid;
    logic [31:0] c_addr, c_wdata, c_ad_o;
    logic [3:0]  c_wstrb;
    logic        c_slot, c_exp, c_ad_oe;
    logic [1:0]  c_st;
    int          ack_cyc, ack_cnt;
    string       tag;
    seen_valid = 0; valid_in_ack = 0; oe_bad = 0; extra_valid = 0;
    c_addr = '0; c_wdata = '0; c_ad_o = '0; c_wstrb = '0;
    c_slot = 0; c_exp = 0; c_ad_oe = 0; c_st = 2'b00;
    ack_cyc = 0; ack_cnt = 0;
    tag = $sformatf("v%0d", idx);
    @(negedge nub_clk);
    nub_startn = 1'b0; nub_ad_i = v.ad; nub_tm1n_i = v.tm1n; nub_tm0n_i = v.tm0n;
    mem_rdata = v.rdata; ready_en = (v.ready_at <= 0);
    @(posedge nub_clk); #1;
    nub_startn = 1'b1; nub_ad_i = v.wdata; nub_tm1n_i = 1'b1; nub_tm0n_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin
        @(posedge nub_clk); #1;
        if (c == 2) nub_ad_i = 32'h0;
      end
      ready_en = (c >= v.ready_at);
      if (mem_valid && !seen_valid) begin
        seen_valid = 1; c_addr = mem_addr; c_wstrb = mem_wstrb; c_wdata = mem_wdata;
        c_slot = mem_myslot; c_exp = mem_myexp;
      end
      if (mem_valid && ack_cyc != 0) extra_valid = 1;
      if (!nub_ackn_o) begin
        ack_cnt++;
        if (ack_cyc == 0) begin
          ack_cyc = c; c_st = {nub_tm1n_o, nub_tm0n_o}; c_ad_o = nub_ad_o;
          c_ad_oe = nub_ad_oe; valid_in_ack = mem_valid;
          if (!nub_ack_oe) oe_bad = 1;
        end
      end
      if (nub_ad_oe && nub_ackn_o) oe_bad = 1;
    end
    ready_en = 1'b0;
    check({tag, " valid"}, 32'(seen_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      check({tag, " addr"}, c_addr, v.exp_addr);
      check({tag, " wstrb"}, 32'(c_wstrb), 32'(v.exp_wstrb));
      check({tag, " myslot"}, 32'(c_slot), 32'(v.exp_slot));
      check({tag, " myexp"}, 32'(c_exp), 32'(v.exp_exp));
      if (!v.tm1n) check({tag, " wdata"}, c_wdata, v.wdata);
    end
    check({tag, " ack_cycle"}, 32'(ack_cyc), 32'(v.exp_ack));
    if (v.exp_ack != 0) begin
      check({tag, " ack_len"}, 32'(ack_cnt), 32'd1);
      check({tag, " status"}, 32'(c_st), 32'(v.exp_st));
      check({tag, " ad_oe"}, 32'(c_ad_oe), 32'(v.exp_ad_oe));
      check({tag, " valid_in_ack"}, 32'(valid_in_ack), 32'd0);
      check({tag, " valid_after_ack"}, 32'(extra_valid), 32'd0);
      if (v.exp_ad_oe) check({tag, " ad_o"}, c_ad_o, v.rdata);
    end
    check({tag, " oe_window"}, 32'(oe_bad), 32'd0);
  endtask

  initial begin
    logic flag;
    vecs[0]  = '{32'hFE000010, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        0,  1'b1, 32'hFE000010, 4'hF, 1'b1, 1'b0, 3, 2'b11, 1'b0};
    vecs[1]  = '{32'hFE000013, 1'b1, 1'b1, 32'h0,        32'h11223344, 0,  1'b1, 32'hFE000010, 4'h0, 1'b1, 1'b0, 3, 2'b11, 1'b1};
    vecs[2]  = '{32'hFE000022, 1'b0, 1'b0, 32'hA5A50000, 32'h0,        0,  1'b1, 32'hFE000020, 4'hC, 1'b1, 1'b0, 3, 2'b11, 1'b0};
    vecs[3]  = '{32'hFE000041, 1'b0, 1'b0, 32'h00005A5A, 32'h0,        0,  1'b1, 32'hFE000040, 4'h3, 1'b1, 1'b0, 3, 2'b11, 1'b0};
    vecs[4]  = '{32'hFE000006, 1'b0, 1'b1, 32'h00770000, 32'h0,        0,  1'b1, 32'hFE000004, 4'h4, 1'b1, 1'b0, 3, 2'b11, 1'b0};
    vecs[5]  = '{32'hFE000003, 1'b0, 1'b0, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 2, 2'b10, 1'b0};
    vecs[6]  = '{32'hF5000000, 1'b0, 1'b0, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 0, 2'b11, 1'b0};
    vecs[7]  = '{32'hE0000100, 1'b1, 1'b0, 32'h0,        32'hCAFEF00D, 0,  1'b1, 32'hE0000100, 4'h0, 1'b0, 1'b1, 3, 2'b11, 1'b1};
    vecs[8]  = '{32'hFE000100, 1'b0, 1'b0, 32'h01020304, 32'h0,        99, 1'b1, 32'hFE000100, 4'hF, 1'b1, 1'b0, 6, 2'b01, 1'b0};
    vecs[9]  = '{32'hFE000104, 1'b1, 1'b0, 32'h0,        32'h55AA55AA, 5,  1'b1, 32'hFE000104, 4'h0, 1'b1, 1'b0, 6, 2'b11, 1'b1};
    vecs[10] = '{32'hFE000108, 1'b1, 1'b0, 32'h0,        32'h87654321, 3,  1'b1, 32'hFE000108, 4'h0, 1'b1, 1'b0, 4, 2'b11, 1'b1};
    vecs[11] = '{32'hFE00000F, 1'b1, 1'b0, 32'h0,        32'h0,        0,  1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 2, 2'b10, 1'b0};

    nub_reset = 1'b1; nub_idn = 4'h1; nub_startn = 1'b1; nub_ad_i = '0;
    nub_tm1n_i = 1'b1; nub_tm0n_i = 1'b1; mem_rdata = '0; ready_en = 1'b0;
    @(posedge nub_clk); #1;
    check("rst ackn", 32'(nub_ackn_o), 32'd1);
    check("rst status", 32'({nub_tm1n_o, nub_tm0n_o}), 32'd3);
    check("rst oes", 32'({nub_ack_oe, nub_ad_oe}), 32'd0);
    check("rst ad_o", nub_ad_o, 32'h0);
    check("rst valid", 32'(mem_valid), 32'd0);
    check("rst addr", mem_addr, 32'h0);
    check("rst wstrb_wdata", 32'(mem_wstrb) | mem_wdata, 32'h0);
    check("rst hits", 32'({mem_myslot, mem_myexp}), 32'd0);
    @(posedge nub_clk);
    @(negedge nub_clk); nub_reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Start during BUSY and during ACK must be ignored
    @(negedge nub_clk);
    nub_startn = 1'b0; nub_ad_i = 32'hFE000100; nub_tm1n_i = 1'b0; nub_tm0n_i = 1'b0;
    ready_en = 1'b0;
    @(negedge nub_clk); nub_startn = 1'b1; nub_ad_i = 32'h12345678; nub_tm1n_i = 1'b1; nub_tm0n_i = 1'b1;
    @(negedge nub_clk); nub_ad_i = 32'h0;
    check("busy valid", 32'(mem_valid), 32'd1);
    check("busy wdata", mem_wdata, 32'h12345678);
    nub_startn = 1'b0; nub_ad_i = 32'hFE000200; nub_tm1n_i = 1'b1;
    @(negedge nub_clk); nub_startn = 1'b1; nub_ad_i = 32'h0; ready_en = 1'b1;
    check("busy start addr", mem_addr, 32'hFE000100);
    check("busy start wstrb", 32'(mem_wstrb), 32'hF);
    @(posedge nub_clk); #1;
    ready_en = 1'b0;
    check("busy ack", 32'({nub_ackn_o, nub_tm1n_o, nub_tm0n_o}), 32'b011);
    nub_startn = 1'b0; nub_ad_i = 32'hFE000300; nub_tm1n_i = 1'b0;
    @(posedge nub_clk); #1;
    nub_startn = 1'b1; nub_ad_i = 32'h0; nub_tm1n_i = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (mem_valid || !nub_ackn_o) flag = 1'b1;
      @(posedge nub_clk); #1;
    end
    check("ack start ignored", 32'(flag), 32'd0);
    check("ack start addr", mem_addr, 32'hFE000100);

    // Reset while BUSY: outputs clear at that edge, no ack afterwards
    @(negedge nub_clk);
    nub_startn = 1'b0; nub_ad_i = 32'hFE000400; nub_tm1n_i = 1'b0; nub_tm0n_i = 1'b0;
    @(negedge nub_clk); nub_startn = 1'b1; nub_ad_i = 32'hAAAA5555; nub_tm1n_i = 1'b1; nub_tm0n_i = 1'b1;
    @(negedge nub_clk); nub_ad_i = 32'h0;
    check("pre-reset valid", 32'(mem_valid), 32'd1);
    nub_reset = 1'b1;
    @(posedge nub_clk); #1;
    check("mid rst valid", 32'(mem_valid), 32'd0);
    check("mid rst addr", mem_addr, 32'h0);
    check("mid rst wdata", mem_wdata, 32'h0);
    check("mid rst ackn", 32'({nub_ackn_o, nub_ack_oe}), 32'b10);
    @(negedge nub_clk); nub_reset = 1'b0; ready_en = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge nub_clk); #1;
      if (mem_valid || !nub_ackn_o || nub_ack_oe) flag = 1'b1;
    end
    check("no ack after reset", 32'(flag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
